// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the shared memory port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if #(parameter int AW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and load/store; data has
// priority, bounded by a starvation counter that forces a fetch grant.
//   state | meaning
//   IDLE  | nothing in flight, may grant
//   WAIT  | access issued, counting down MEM_LAT cycles
//   RESP  | rvalid to owner, may grant the next access
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q;
  logic            own_d_q;
  logic            byte_q;
  logic            we_q;
  logic [1:0]      off_q;
  logic [31:0]     if_rdata_q, d_rdata_q;
  logic            open, d_win, if_win, grant, last_wait;
  logic [7:0]      sel_byte;

  // Grants are blocked while reset is asserted and while an access is in flight.
  assign open      = rst_n && (state_q != WAIT);
  assign d_win     = open && bus.d_req && ((starve_q < SW'(STARVE_MAX)) || !bus.if_req);
  assign if_win    = open && bus.if_req && !d_win;
  assign grant     = d_win || if_win;
  assign last_wait = (state_q == WAIT) && (lat_q == '0);
  assign sel_byte  = bus.mem_rdata[8*off_q +: 8];

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = grant ? WAIT : IDLE;
        lat_d   = LW'(MEM_LAT - 1);
      end
      WAIT: begin
        if (lat_q == '0) state_d = RESP;
        else             lat_d   = lat_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = grant;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_win) begin
      bus.mem_we   = bus.d_we;
      bus.mem_addr = bus.d_addr & ~AW'(3);
      if (bus.d_byte) begin
        bus.mem_be    = 4'b0001 << bus.d_addr[1:0];
        bus.mem_wdata = {4{bus.d_wdata[7:0]}};
      end else begin
        bus.mem_be    = 4'hF;
        bus.mem_wdata = bus.d_wdata;
      end
    end else if (if_win) begin
      bus.mem_addr = bus.if_addr & ~AW'(3);
      bus.mem_be   = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      own_d_q    <= 1'b0;
      byte_q     <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= 2'b00;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (!bus.if_req || if_win)                       starve_q <= '0;
      else if (d_win && (starve_q < SW'(STARVE_MAX)))  starve_q <= starve_q + 1'b1;
      if (grant) begin
        own_d_q <= d_win;
        byte_q  <= bus.d_byte;
        we_q    <= bus.d_we;
        off_q   <= bus.d_addr[1:0];
      end
      // Stores report completion with zero data; byte loads are zero-extended.
      if (last_wait) begin
        if (own_d_q) d_rdata_q  <= we_q ? '0 : (byte_q ? {24'b0, sel_byte} : bus.mem_rdata);
        else         if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = (state_q == RESP) && !own_d_q;
  assign bus.d_rvalid  = (state_q == RESP) && own_d_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
